// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle integer divider: op select and FSM states.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(div_op_e sel);
        return (sel == DIV_OP_DIV) || (sel == DIV_OP_REM);
    endfunction

    function automatic logic op_is_div(div_op_e sel);
        return (sel == DIV_OP_DIV) || (sel == DIV_OP_DIVU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider on operand magnitudes with post-correction of signs.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    div_op_e            op_q, op_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               special_q, special_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               dbz_q, dbz_d;

    // Request decode on the raw inputs, used only when a start is accepted
    div_op_e            op_in;
    logic               in_signed;
    logic               in_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               in_zero;
    logic               in_ovf;

    always_comb begin
        op_in     = div_op_e'(op);
        in_signed = op_is_signed(op_in);
        in_div    = op_is_div(op_in);
        a_neg     = in_signed & a[WIDTH-1];
        b_neg     = in_signed & b[WIDTH-1];
        a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
        in_zero   = (b == '0);
        in_ovf    = in_signed && (a == MOST_NEG) && (b == '1);
    end

    // One restoring step: shift {rem,quo} and trial-subtract with a borrow bit
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               step_ok;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_q};
        step_ok = ~diff[WIDTH];
    end

    // Sign correction applied in FIX
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        quo_fix = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
        if (special_q) begin
            fix_res = quo_q;
        end else if (op_is_div(op_q)) begin
            fix_res = quo_fix;
        end else begin
            fix_res = rem_fix;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        special_d  = special_q;
        dbz_pend_d = dbz_pend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        y_d        = y_q;
        dbz_d      = dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start && !flush) begin
                    op_d       = op_in;
                    neg_quo_d  = in_div & (a_neg ^ b_neg);
                    neg_rem_d  = ~in_div & a_neg;
                    divisor_d  = b_mag;
                    rem_d      = '0;
                    count_d    = '0;
                    busy_d     = 1'b1;
                    if (in_zero) begin
                        special_d  = 1'b1;
                        dbz_pend_d = 1'b1;
                        quo_d      = in_div ? '1 : a;
                        state_d    = ST_FIX;
                    end else if (in_ovf) begin
                        special_d  = 1'b1;
                        dbz_pend_d = 1'b0;
                        quo_d      = in_div ? MOST_NEG : '0;
                        state_d    = ST_FIX;
                    end else begin
                        special_d  = 1'b0;
                        dbz_pend_d = 1'b0;
                        quo_d      = a_mag;
                        state_d    = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    count_d = '0;
                end else begin
                    rem_d   = step_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_d   = {quo_q[WIDTH-2:0], step_ok};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                count_d = '0;
                if (!flush) begin
                    y_d    = fix_res;
                    dbz_d  = dbz_pend_q;
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            op_q       <= DIV_OP_DIV;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            y_q        <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            special_q  <= special_d;
            dbz_pend_q <= dbz_pend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            y_q        <= y_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign y           = y_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against a countdown/arithmetic reference model.
module tb_div_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .flush       (flush),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .y           (y),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {div_by_zero, y} from plain arithmetic
    function automatic logic [W:0] ref_calc(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] d);
        logic sgn;
        logic dv;
        int   sx;
        int   sd;
        sgn = (o == 2'b00) || (o == 2'b10);
        dv  = (o == 2'b00) || (o == 2'b01);
        sx  = x;
        sd  = d;
        if (d == 0) return {1'b1, (dv ? 32'hFFFF_FFFF : x)};
        if (sgn && x == MIN_NEG && d == 32'hFFFF_FFFF) return {1'b0, (dv ? MIN_NEG : 32'h0)};
        if (sgn) return {1'b0, (dv ? 32'(sx / sd) : 32'(sx % sd))};
        return {1'b0, (dv ? x / d : x % d)};
    endfunction

    function automatic bit ref_special(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] d);
        return (d == 0) || ((o == 2'b00 || o == 2'b10) && x == MIN_NEG && d == 32'hFFFF_FFFF);
    endfunction

    // Model: cycles remaining until the result appears; 0 means idle
    int           m_left;
    logic         m_busy;
    logic         m_done;
    logic [W-1:0] m_y;
    logic         m_dbz;
    logic [W:0]   m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_y    <= '0;
            m_dbz  <= 1'b0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start && !flush) begin
                    m_res  <= ref_calc(op, a, b);
                    m_left <= ref_special(op, a, b) ? 1 : W + 1;
                    m_busy <= 1'b1;
                end
            end else if (flush) begin
                m_left <= 0;
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_left <= 0;
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_y    <= m_res[W-1:0];
                m_dbz  <= m_res[W];
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        chk("busy", W'(busy), W'(m_busy));
        chk("done", W'(done), W'(m_done));
        chk("y", y, m_y);
        chk("div_by_zero", W'(div_by_zero), W'(m_dbz));
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done after %0d cycles", n);
        end
    endtask

    // Issue one op at a negedge and check the literal result and latency
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] d, input logic [W-1:0] exp_y,
                          input logic exp_dbz, input int exp_lat);
        int n;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = d;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk({name, " y"}, y, exp_y);
        chk({name, " dbz"}, W'(div_by_zero), W'(exp_dbz));
        chk({name, " latency"}, W'(n), W'(exp_lat));
    endtask

    initial begin
        int n;
        int seen_done;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", W'(busy), '0);
        chk("reset done", W'(done), '0);
        chk("reset y", y, '0);
        chk("reset dbz", W'(div_by_zero), '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("divu 100/7", 2'b01, 100, 7, 14, 1'b0, 33);
        run_op("remu 100/7", 2'b11, 100, 7, 2, 1'b0, 33);
        run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("div 7/-2", 2'b00, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("rem 7/-2", 2'b10, 7, 32'hFFFF_FFFE, 1, 1'b0, 33);
        run_op("div 5/0", 2'b00, 5, 0, 32'hFFFF_FFFF, 1'b1, 1);
        run_op("rem 5/0", 2'b10, 5, 0, 5, 1'b1, 1);
        run_op("divu min/0", 2'b01, MIN_NEG, 0, 32'hFFFF_FFFF, 1'b1, 1);
        run_op("div ovf", 2'b00, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1'b0, 1);
        run_op("rem ovf", 2'b10, MIN_NEG, 32'hFFFF_FFFF, 0, 1'b0, 1);

        // Back-to-back: second start lands in the done cycle of the first
        run_op("b2b divu", 2'b01, 10000, 3000, 3, 1'b0, 33);
        run_op("b2b remu", 2'b11, 10000, 3000, 1000, 1'b0, 33);

        // Start while busy is ignored
        start = 1'b1; op = 2'b01; a = 100; b = 7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 9; b = 2;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ignored start y", y, 14);
        chk("ignored start latency", W'(n + 5), 33);

        // Flush mid-CALC: no done, y holds
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 1000; b = 3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy drop", W'(busy), '0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("flush no done", W'(seen_done), '0);
        chk("flush y held", y, 14);

        // Flush and start together in IDLE drop the request
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 50; b = 5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush+start busy", W'(busy), '0);
        @(negedge clk);

        // Reset mid-CALC clears outputs immediately
        start = 1'b1; op = 2'b01; a = 100; b = 7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", W'(busy), '0);
        chk("midreset done", W'(done), '0);
        chk("midreset y", y, '0);
        chk("midreset dbz", W'(div_by_zero), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic; the compare process checks every cycle
        for (int i = 0; i < 6000; i++) begin
            int r;
            r     = int'($urandom_range(0, 7));
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 59) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 5000));
            if ($urandom_range(0, 1) == 0) a = ~a + 1;
            case (r)
                0: b = '0;
                1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = ~32'($urandom_range(0, 14));
                default: b = 32'($urandom);
            endcase
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
